// File: rtl/load_store_unit.sv
// load_store_unit
//   Turns one CPU load/store request at a time into one or two doubleword
//   memory accesses. Loads are shifted and sign- or zero-extended. Stores are
//   placed on their byte lanes. Only one request is in flight at a time.
//
//   Build option: LSU_MISALIGN_SPLIT_EN
//     defined   : an access that crosses a doubleword boundary is split into
//                 two memory accesses (ACC0 then ACC1).
//     undefined : such an access gets no memory strobe. It completes after
//                 one cycle with resp_misaligned_out = 1.
//
//   Ports
//     clk, reset             rising-edge clock, synchronous active-high reset
//     req_*                  request handshake: valid/ready, write, size,
//                            unsigned, addr, wdata
//     resp_*                 one-cycle completion pulse; rdata and misaligned
//                            are held until the next response
//     mem_*                  doubleword-aligned memory port; read data is
//                            valid in the same cycle as mem_sel_out
module load_store_unit #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic              req_write_in,
  input  logic [1:0]        req_size_in,
  input  logic              req_unsigned_in,
  input  logic [ADDR_W-1:0] req_addr_in,
  input  logic [63:0]       req_wdata_in,
  output logic              resp_valid_out,
  output logic [63:0]       resp_rdata_out,
  output logic              resp_misaligned_out,
  output logic [ADDR_W-1:0] mem_address_out,
  output logic              mem_sel_out,
  output logic [7:0]        mem_write_mask_out,
  output logic [63:0]       mem_write_value_out,
  input  logic [63:0]       mem_read_value_in
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t            state_reg;
  logic              write_reg;
  logic              unsigned_reg;
  logic              span_reg;
  logic [1:0]        size_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [63:0]       wdata_reg;
  logic [63:0]       lo_reg;

  logic              resp_valid_reg;
  logic [63:0]       resp_rdata_reg;
  logic              resp_misaligned_reg;
  logic [ADDR_W-1:0] mem_address_reg;
  logic              mem_sel_reg;
  logic [7:0]        mem_mask_reg;
  logic [63:0]       mem_value_reg;

  assign req_ready_out       = (state_reg == IDLE);
  assign resp_valid_out      = resp_valid_reg;
  assign resp_rdata_out      = resp_rdata_reg;
  assign resp_misaligned_out = resp_misaligned_reg;
  assign mem_address_out     = mem_address_reg;
  assign mem_sel_out         = mem_sel_reg;
  assign mem_write_mask_out  = mem_mask_reg;
  assign mem_write_value_out = mem_value_reg;

  // First-access lane geometry, taken straight from the incoming request.
  logic [2:0]  req_off;
  logic [3:0]  req_bytes;
  logic [7:0]  req_lane_base;
  logic        req_span;
  logic [7:0]  req_mask;
  logic [63:0] req_value;

  assign req_off       = req_addr_in[2:0];
  assign req_bytes     = 4'd1 << req_size_in;
  assign req_lane_base = 8'hFF >> (4'd8 - req_bytes);
  assign req_span      = ({1'b0, req_off} + req_bytes) > 4'd8;
  assign req_mask      = req_lane_base << req_off;   // lanes past 7 drop off
  assign req_value     = req_wdata_in << {req_off, 3'b000};

  // Second-access geometry, taken from the latched request. The lanes that
  // spill past lane 7 in the first access end up as the low lanes here.
  logic [2:0]        lat_off;
  logic [3:0]        lat_bytes;
  logic [7:0]        lat_lane_base;
  logic [7:0]        lat_mask_hi;
  logic [63:0]       lat_value_hi;
  logic [ADDR_W-1:0] lat_next_addr;

  assign lat_off       = addr_reg[2:0];
  assign lat_bytes     = 4'd1 << size_reg;
  assign lat_lane_base = 8'hFF >> (4'd8 - lat_bytes);
  assign lat_mask_hi   = lat_lane_base >> (4'd8 - {1'b0, lat_off});
  assign lat_value_hi  = wdata_reg >> (7'd64 - {1'b0, lat_off, 3'b000});
  assign lat_next_addr = {addr_reg[ADDR_W-1:3], 3'b000} + ADDR_W'(8);

  // Load extraction. In ACC1 the low half comes from the register and the
  // high half comes from the bus. In ACC0 the high half is zero. A shift by
  // 64 gives zero, so an offset of 0 leaves the high half out.
  logic [63:0] ld_lo, ld_hi, ld_raw, ld_result;
  logic        ld_signed;

  always_comb begin
    ld_lo     = (state_reg == ACC1) ? lo_reg : mem_read_value_in;
    ld_hi     = (state_reg == ACC1) ? mem_read_value_in : 64'h0;
    ld_raw    = (ld_lo >> {lat_off, 3'b000}) |
                (ld_hi << (7'd64 - {1'b0, lat_off, 3'b000}));
    ld_signed = ~unsigned_reg;
    ld_result = ld_raw;
    unique case (size_reg)
      2'd0:    ld_result = {{56{ld_signed & ld_raw[7]}},  ld_raw[7:0]};
      2'd1:    ld_result = {{48{ld_signed & ld_raw[15]}}, ld_raw[15:0]};
      2'd2:    ld_result = {{32{ld_signed & ld_raw[31]}}, ld_raw[31:0]};
      default: ld_result = ld_raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg           <= IDLE;
      write_reg           <= 1'b0;
      unsigned_reg        <= 1'b0;
      span_reg            <= 1'b0;
      size_reg            <= 2'd0;
      addr_reg            <= '0;
      wdata_reg           <= 64'h0;
      lo_reg              <= 64'h0;
      resp_valid_reg      <= 1'b0;
      resp_rdata_reg      <= 64'h0;
      resp_misaligned_reg <= 1'b0;
      mem_address_reg     <= '0;
      mem_sel_reg         <= 1'b0;
      mem_mask_reg        <= 8'h00;
      mem_value_reg       <= 64'h0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (req_valid_in) begin
            write_reg    <= req_write_in;
            unsigned_reg <= req_unsigned_in;
            span_reg     <= req_span;
            size_reg     <= req_size_in;
            addr_reg     <= req_addr_in;
            wdata_reg    <= req_wdata_in;
            if (req_span && !SPLIT_EN) begin
              // Rejected without touching memory.
              state_reg           <= RESP;
              resp_valid_reg      <= 1'b1;
              resp_rdata_reg      <= 64'h0;
              resp_misaligned_reg <= 1'b1;
            end else begin
              state_reg       <= ACC0;
              mem_sel_reg     <= 1'b1;
              mem_address_reg <= {req_addr_in[ADDR_W-1:3], 3'b000};
              mem_mask_reg    <= req_write_in ? req_mask : 8'h00;
              mem_value_reg   <= req_value;
            end
          end
        end
        ACC0: begin
          lo_reg <= mem_read_value_in;
          if (span_reg) begin
            state_reg       <= ACC1;
            mem_address_reg <= lat_next_addr;
            mem_mask_reg    <= write_reg ? lat_mask_hi : 8'h00;
            mem_value_reg   <= lat_value_hi;
          end else begin
            state_reg           <= RESP;
            mem_sel_reg         <= 1'b0;
            mem_address_reg     <= '0;
            mem_mask_reg        <= 8'h00;
            mem_value_reg       <= 64'h0;
            resp_valid_reg      <= 1'b1;
            resp_rdata_reg      <= write_reg ? 64'h0 : ld_result;
            resp_misaligned_reg <= 1'b0;
          end
        end
        ACC1: begin
          state_reg           <= RESP;
          mem_sel_reg         <= 1'b0;
          mem_address_reg     <= '0;
          mem_mask_reg        <= 8'h00;
          mem_value_reg       <= 64'h0;
          resp_valid_reg      <= 1'b1;
          resp_rdata_reg      <= write_reg ? 64'h0 : ld_result;
          resp_misaligned_reg <= 1'b0;
        end
        RESP: begin
          state_reg      <= IDLE;
          resp_valid_reg <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: ADDR_W, 64, width of request and memory address buses.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req_valid_in  input  1  CPU request present.
REQ-005 SHALL have port: req_ready_out  output  1  unit can accept a request.
REQ-006 SHALL have port: req_write_in  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_size_in  input  2  0 = byte, 1 = half, 2 = word, 3 = double.
REQ-008 SHALL have port: req_unsigned_in  input  1  1 = zero-extend load, 0 = sign-extend load.
REQ-009 SHALL have port: req_addr_in  input  ADDR_W  byte address.
REQ-010 SHALL have port: req_wdata_in  input  64  store data, right-justified.
REQ-011 SHALL have port: resp_valid_out  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: resp_rdata_out  output  64  extended load result.
REQ-013 SHALL have port: resp_misaligned_out  output  1  access rejected as misaligned.
REQ-014 SHALL have port: mem_address_out  output  ADDR_W  doubleword-aligned memory address (bits [2:0] = 0).
REQ-015 SHALL have port: mem_sel_out  output  1  memory access strobe.
REQ-016 SHALL have port: mem_write_mask_out  output  8  byte-lane write enables; bit i enables mem_write_value_out[8i+7:8i].
REQ-017 SHALL have port: mem_write_value_out  output  64  lane-aligned store data.
REQ-018 SHALL have port: mem_read_value_in  input  64  memory read data; valid in the same cycle mem_sel_out is high.

Function
REQ-019 States: IDLE, ACC0, ACC1, RESP; req_ready_out = 1 only in IDLE.
REQ-020 Accept when req_valid_in && req_ready_out; latch write, size, unsigned, addr, wdata; n = 1 << size; o = addr[2:0].
REQ-021 Spanning access: o + n > 8; otherwise single access.
REQ-022 IDLE -> ACC0 on accept (spanning-reject case: see REQ-034).
REQ-023 ACC0: mem_sel_out = 1; mem_address_out = {addr[ADDR_W-1:3], 3'b0}; mask = low 8 bits of (((1<<n)-1) << o); write value = wdata << 8*o.
REQ-024 ACC1 (spanning only): mem_address_out = previous doubleword address + 8, modulo 2^ADDR_W; mask = bits [15:8] of the REQ-023 shifted mask; write value = wdata >> 8*(8-o).
REQ-025 Loads: mem_write_mask_out = 0 in all states; read data captured at end of ACC0 (lo) and ACC1 (hi; 0 when not spanning).
REQ-026 Load result = n bytes of ({hi,lo} >> 8*o), sign- or zero-extended per req_unsigned_in; stores return resp_rdata_out = 0.
REQ-027 ACC0 -> ACC1 if spanning, else -> RESP; ACC1 -> RESP.
REQ-028 RESP: resp_valid_out = 1 for exactly one cycle; resp_rdata_out and resp_misaligned_out held until the next response; RESP -> IDLE.
REQ-029 Latency from accept edge to resp_valid_out: 2 cycles single access, 3 cycles spanning.
REQ-030 Outside ACC0/ACC1: mem_sel_out = 0, mem_write_mask_out = 0, mem_write_value_out = 0, mem_address_out = 0.
REQ-031 Request inputs are ignored when req_ready_out = 0; no request queuing.

Reset
REQ-032 reset high at a rising edge: state -> IDLE; all outputs 0 except req_ready_out = 1; any in-flight access aborted with no response and no further memory strobe.

Configuration
REQ-033 Macro LSU_MISALIGN_SPLIT_EN defined: spanning accesses split per REQ-023..REQ-027; resp_misaligned_out always 0.
REQ-034 Macro undefined: spanning request goes IDLE -> RESP with no memory strobe; resp_valid_out with resp_misaligned_out = 1, resp_rdata_out = 0; latency 1 cycle; non-spanning accesses unchanged.

Verification
REQ-035 Store double 0x1122334455667788 @0x40 -> one strobe, addr 0x40, mask 0xFF, value 0x1122334455667788; resp 2 cycles later.
REQ-036 Store byte 0xAB @0x43 -> addr 0x40, mask 0x08, value 0x00000000AB000000; load byte signed @0x43 -> rdata 0xFFFFFFFFFFFFFFAB; unsigned load -> 0xAB.
REQ-037 With macro, store word 0xDEADBEEF @0x46 -> ACC0 addr 0x40 mask 0xC0 value[63:48] = 0xBEEF; ACC1 addr 0x48 mask 0x03 value[15:0] = 0xDEAD; load word unsigned @0x46 -> 0xDEADBEEF after 3 cycles.
REQ-038 Without macro, load half @0x47 -> no mem_sel_out, resp_misaligned_out = 1, rdata 0, resp 1 cycle after accept.
REQ-039 Spanning double @0xFFFFFFFFFFFFFFFC with macro -> ACC1 address wraps to 0x0.
REQ-040 Reset asserted during ACC1 -> next cycle mem_sel_out = 0, resp_valid_out never pulses, req_ready_out = 1.
